// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   - Baud select codes understood by the UART byte transmitter.
//   - Scheduler state encoding (also exported on the state_dbg port).
//   - Width of the transmit timeout counter.
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  localparam int TMO_W = 20;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Link between the scheduler and the UART byte transmitter.
//   master (scheduler)  : drives tx_send_en, tx_databyte, tx_baud_set
//   slave (transmitter) : drives tx_busy, tx_done
// Handshake: tx_send_en is a one-cycle start pulse; tx_databyte is held
// from that pulse until the byte completes. The transmitter raises tx_busy
// while shifting and pulses tx_done once when the frame is finished.
interface uart_tx_sched_if;
  logic       tx_send_en;
  logic [7:0] tx_databyte;
  logic [2:0] tx_baud_set;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_send_en,
    output tx_databyte,
    output tx_baud_set,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_send_en,
    input  tx_databyte,
    input  tx_baud_set,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter.
//   clk, rst : clock, asynchronous active-high reset
//   req      : request vector
//   adv      : accept the current grant and move the pointer past it
//   gnt_oh   : one-hot grant (combinational)
//   gnt_idx  : encoded grant index (combinational)
//   any      : at least one request present
// The search starts at the internal pointer and wraps, so the requester
// just served becomes lowest priority on the next round.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] ptr;

  always_comb begin
    int c;
    c       = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any       = 1'b1;
        gnt_idx   = IW'(c);
        gnt_oh[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && any) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART byte transmitter among N_REQ
// requesters.
//   sys_clk, sys_rst         : clock, asynchronous active-high reset
//   req, req_data            : level requests, byte i at [8i+7:8i]
//   gnt, done                : one-hot pulses (byte captured / finished)
//   cfg_baud_set/cfg_baud_wr : baud select write port
//   tx                       : transmitter link (send/data/baud, busy/done)
//   busy, timeout_err        : scheduler active, abort pulse
//   state_dbg                : current FSM state
// All outputs are registered; each pulse appears in the cycle after the
// FSM decision that causes it.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int         N_REQ          = 4,
  parameter logic [2:0] BAUD_RST       = BAUD_9600,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 600000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  input  logic [2:0]           cfg_baud_set,
  input  logic                 cfg_baud_wr,
  uart_tx_sched_if.master      tx,
  output logic                 busy,
  output logic                 timeout_err,
  output state_t               state_dbg
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t             state, state_n;
  logic [N_REQ-1:0]   gnt_q, gnt_n, done_q, done_n;
  logic               send_q, send_n, busy_q, busy_n, tmo_err_q, tmo_err_n;
  logic [7:0]         data_q, data_n;
  logic [2:0]         baud_q, baud_n, pend_val_q, pend_val_n;
  logic               pend_q, pend_n;
  logic [IDX_W-1:0]   owner_q, owner_n;
  logic [TMO_W-1:0]   tmo_q, tmo_n;
  logic [GAP_W-1:0]   gap_q, gap_n;

  logic [N_REQ-1:0]   arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any, arb_adv;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .req     (req),
    .adv     (arb_adv),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_n    = state;
    gnt_n      = '0;
    done_n     = '0;
    send_n     = 1'b0;
    tmo_err_n  = 1'b0;
    data_n     = data_q;
    baud_n     = baud_q;
    pend_n     = pend_q;
    pend_val_n = pend_val_q;
    owner_n    = owner_q;
    tmo_n      = tmo_q;
    gap_n      = gap_q;
    arb_adv    = 1'b0;

    case (state)
      ST_IDLE: begin
        // Baud changes take the IDLE cycle they land in; no grant then.
        if (pend_q) begin
          baud_n = pend_val_q;
          pend_n = 1'b0;
          if (cfg_baud_wr) begin
            pend_n     = 1'b1;
            pend_val_n = cfg_baud_set;
          end
        end else if (cfg_baud_wr) begin
          baud_n = cfg_baud_set;
        end else if (arb_any) begin
          gnt_n   = arb_oh;
          data_n  = req_data[8*int'(arb_idx) +: 8];
          owner_n = arb_idx;
          arb_adv = 1'b1;
          state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        send_n  = 1'b1;
        tmo_n   = '0;
        state_n = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        // tx_done has priority over an expiring timeout.
        if (tx.tx_done) begin
          done_n[owner_q] = 1'b1;
          state_n         = ST_DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          done_n[owner_q] = 1'b1;
          tmo_err_n       = 1'b1;
          gap_n           = '0;
          state_n         = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        end else begin
          tmo_n = tmo_q + 1'b1;
          if (state == ST_WAIT_BUSY && tx.tx_busy) state_n = ST_WAIT_DONE;
        end
      end
      ST_DONE: begin
        gap_n   = '0;
        state_n = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_n = ST_IDLE;
        else gap_n = gap_q + 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // Outside IDLE a baud write is parked; the last write wins.
    if (state != ST_IDLE && cfg_baud_wr) begin
      pend_n     = 1'b1;
      pend_val_n = cfg_baud_set;
    end

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      send_q     <= 1'b0;
      busy_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      data_q     <= '0;
      baud_q     <= BAUD_RST;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      owner_q    <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
    end else begin
      state      <= state_n;
      gnt_q      <= gnt_n;
      done_q     <= done_n;
      send_q     <= send_n;
      busy_q     <= busy_n;
      tmo_err_q  <= tmo_err_n;
      data_q     <= data_n;
      baud_q     <= baud_n;
      pend_q     <= pend_n;
      pend_val_q <= pend_val_n;
      owner_q    <= owner_n;
      tmo_q      <= tmo_n;
      gap_q      <= gap_n;
    end
  end

  assign gnt            = gnt_q;
  assign done           = done_q;
  assign busy           = busy_q;
  assign timeout_err    = tmo_err_q;
  assign state_dbg      = state;
  assign tx.tx_send_en  = send_q;
  assign tx.tx_databyte = data_q;
  assign tx.tx_baud_set = baud_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int G = 4;
  localparam int T = 40;

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic sys_rst;
  always #5 sys_clk = ~sys_clk;

  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt, done;
  logic [2:0]  cfg_baud_set;
  logic        cfg_baud_wr;
  logic        busy, timeout_err;
  state_t      state_dbg;

  uart_tx_sched_if tx_if ();

  uart_tx_sched #(
    .N_REQ(4), .BAUD_RST(3'd1), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .done         (done),
    .cfg_baud_set (cfg_baud_set),
    .cfg_baud_wr  (cfg_baud_wr),
    .tx           (tx_if.master),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .state_dbg    (state_dbg)
  );

  // ---------------- transmitter stub ----------------
  // busy rises 2 cycles after send_en, done pulses 20 cycles after it.
  bit model_en = 1'b1;
  bit m_act = 1'b0;
  int m_cnt = 0;
  always @(negedge sys_clk) begin
    if (model_en && tx_if.tx_send_en) begin
      m_act = 1'b1;
      m_cnt = 0;
    end else if (m_act) begin
      m_cnt++;
    end
    tx_if.tx_busy = m_act && m_cnt >= 2 && m_cnt < 20;
    tx_if.tx_done = m_act && m_cnt == 20;
    if (m_act && m_cnt == 20) m_act = 1'b0;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];
  int          got_gnt_q[$];
  int          send_cyc_q[$];
  logic [7:0]  send_data_q[$];
  int gnt_hits[4];
  int done_hits[4];
  int done_total = 0;
  int cyc = 0;

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (gnt != 4'b0) begin
      got_gnt_q.push_back(oh_idx(gnt));
      gnt_hits[oh_idx(gnt)]++;
    end
    if (done != 4'b0) begin
      done_hits[oh_idx(done)]++;
      done_total++;
    end
    if (tx_if.tx_send_en) begin
      send_cyc_q.push_back(cyc);
      send_data_q.push_back(tx_if.tx_databyte);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    for (int i = 0; i < budget && state_dbg !== s; i++) @(negedge sys_clk);
    chk(tag, 32'(state_dbg), 32'(s));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge sys_clk);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},  32'(gnt), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_send"}, 32'(tx_if.tx_send_en), 32'd0);
    chk({tag, "_data"}, 32'(tx_if.tx_databyte), 32'd0);
    chk({tag, "_baud"}, 32'(tx_if.tx_baud_set), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tmo"},  32'(timeout_err), 32'd0);
    chk({tag, "_st"},   32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int gnt2_pre, done2_pre, done1_pre, done_pre;
    sys_rst = 1'b1; req = '0; req_data = '0;
    cfg_baud_set = '0; cfg_baud_wr = 1'b0;
    tick(3);
    chk_reset_vals("rst");
    sys_rst = 1'b0;
    tick(1);

    // Single byte with full timing.
    req = 4'b0001; req_data[7:0] = 8'hA5;
    tick(1);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_load", 32'(state_dbg), 32'(ST_LOAD));
    req = '0;
    tick(1);
    chk("t1_send", 32'(tx_if.tx_send_en), 32'd1);
    chk("t1_data", 32'(tx_if.tx_databyte), 32'hA5);
    chk("t1_gnt_off", 32'(gnt), 32'd0);
    tick(20);
    chk("t1_done_early", 32'(done), 32'd0);
    chk("t1_wdone", 32'(state_dbg), 32'(ST_WAIT_DONE));
    tick(1);
    chk("t1_done", 32'(done), 32'h1);
    tick(4);
    chk("t1_busy_gap", 32'(busy), 32'd1);
    tick(1);
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_idle", 32'(state_dbg), 32'(ST_IDLE));

    // All four requesting: strict rotation from a fresh pointer.
    sys_rst = 1'b1; tick(2); sys_rst = 1'b0; tick(1);
    got_gnt_q.delete(); send_cyc_q.delete(); send_data_q.delete(); exp_q.delete();
    for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) exp_q.push_back(32'(i));
    req = 4'b1111; req_data = 32'h13121110;
    for (int i = 0; i < 600 && got_gnt_q.size() < 8; i++) @(negedge sys_clk);
    req = '0;
    wait_idle(100, "t2_idle");
    chk("t2_ngnt", 32'(got_gnt_q.size()), 32'd8);
    chk("t2_nsend", 32'(send_cyc_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < got_gnt_q.size() && k < send_data_q.size(); k++) begin
      chk($sformatf("t2_order%0d", k), 32'(got_gnt_q[k]), exp_q[k]);
      chk($sformatf("t2_data%0d", k), 32'(send_data_q[k]), 32'h10 + exp_q[k]);
    end
    for (int k = 1; k < send_cyc_q.size(); k++)
      chk($sformatf("t2_spacing%0d", k),
          32'(send_cyc_q[k] - send_cyc_q[k-1] >= G + 3), 32'd1);

    // Baud writes while busy: deferred, last write wins, grant delayed.
    req = 4'b0010; req_data[15:8] = 8'h3C;
    wait_state(ST_WAIT_DONE, 30, "t3_wd");
    req = '0;
    cfg_baud_set = 3'd4; cfg_baud_wr = 1'b1;
    tick(1);
    cfg_baud_wr = 1'b0;
    chk("t3_baud_hold1", 32'(tx_if.tx_baud_set), 32'd1);
    wait_state(ST_GAP, 40, "t3_gap");
    cfg_baud_set = 3'd2; cfg_baud_wr = 1'b1;
    tick(1);
    cfg_baud_wr = 1'b0;
    req = 4'b0100; req_data[23:16] = 8'h66;
    chk("t3_baud_hold2", 32'(tx_if.tx_baud_set), 32'd1);
    wait_state(ST_IDLE, 10, "t3_idle");
    chk("t3_baud_hold3", 32'(tx_if.tx_baud_set), 32'd1);
    tick(1);
    chk("t3_baud_new", 32'(tx_if.tx_baud_set), 32'd2);
    chk("t3_no_gnt", 32'(gnt), 32'd0);
    chk("t3_still_idle", 32'(state_dbg), 32'(ST_IDLE));
    tick(1);
    chk("t3_gnt", 32'(gnt), 32'h4);
    req = '0;
    wait_idle(60, "t3_end");

    // Transmitter silent: abort after exactly T cycles in the wait states.
    model_en = 1'b0;
    req = 4'b1000; req_data[31:24] = 8'hC3;
    wait_state(ST_WAIT_BUSY, 5, "t4_wb");
    req = '0;
    tick(T - 1);
    chk("t4_tmo_early", 32'(timeout_err), 32'd0);
    chk("t4_done_early", 32'(done), 32'd0);
    tick(1);
    chk("t4_tmo", 32'(timeout_err), 32'd1);
    chk("t4_done", 32'(done), 32'h8);
    chk("t4_gap", 32'(state_dbg), 32'(ST_GAP));
    tick(1);
    chk("t4_tmo_pulse", 32'(timeout_err), 32'd0);
    model_en = 1'b1;
    wait_idle(20, "t4_idle");
    req = 4'b0001; req_data[7:0] = 8'h5A;
    wait_state(ST_LOAD, 5, "t4_load");
    chk("t4_gnt_next", 32'(gnt), 32'h1);
    req = '0;
    tick(1);
    chk("t4_data_next", 32'(tx_if.tx_databyte), 32'h5A);
    for (int i = 0; i < 40 && done === 4'b0; i++) @(negedge sys_clk);
    chk("t4_done_next", 32'(done), 32'h1);
    chk("t4_tmo_next", 32'(timeout_err), 32'd0);
    wait_idle(20, "t4_end");

    // Reset in the middle of a byte; the late tx_done must be ignored.
    req = 4'b0001; req_data[7:0] = 8'h77;
    wait_state(ST_WAIT_DONE, 10, "t5_wd");
    req = '0;
    sys_rst = 1'b1;
    tick(1);
    chk_reset_vals("t5");
    sys_rst = 1'b0;
    done_pre = done_total;
    tick(30);
    chk("t5_no_done", 32'(done_total), 32'(done_pre));
    chk("t5_idle", 32'(state_dbg), 32'(ST_IDLE));
    chk("t5_busy", 32'(busy), 32'd0);

    // Request raised and withdrawn while another byte is in flight.
    gnt2_pre = gnt_hits[2]; done2_pre = done_hits[2]; done1_pre = done_hits[1];
    req = 4'b0010; req_data[15:8] = 8'h81;
    wait_state(ST_LOAD, 5, "t6_load");
    req = '0;
    wait_state(ST_WAIT_DONE, 10, "t6_wd");
    req = 4'b0100; req_data[23:16] = 8'h99;
    tick(3);
    req = '0;
    wait_idle(60, "t6_idle");
    tick(5);
    chk("t6_no_gnt2", 32'(gnt_hits[2]), 32'(gnt2_pre));
    chk("t6_no_done2", 32'(done_hits[2]), 32'(done2_pre));
    chk("t6_done1", 32'(done_hits[1]), 32'(done1_pre + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
